// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate slice.
//   CAPACITY_DEF  - default number of lot spaces
//   PASSWORD_*    - gate password codes shared by the gate FSM and its bench
//   gate_state_t  - gate FSM state encoding
//   occ_op_t      - occupancy update selector used by the sensor conditioner
package parking_pkg;

   localparam int unsigned CAPACITY_DEF = 8;

   localparam logic [1:0] PASSWORD_A = 2'b01;
   localparam logic [1:0] PASSWORD_B = 2'b10;

   typedef enum logic [1:0] {
      GATE_IDLE      = 2'b00,
      GATE_WAIT_PASS = 2'b01,
      GATE_OPEN      = 2'b10,
      GATE_ALARM     = 2'b11
   } gate_state_t;

   typedef enum logic [1:0] {
      OCC_HOLD = 2'b00,
      OCC_INC  = 2'b01,
      OCC_DEC  = 2'b10
   } occ_op_t;

endpackage

// File: rtl/parking_sensor_conditioner_if.sv
// Signal bundle between the raw sensor side / gate controller and the
// parking sensor conditioner.
//   sensor_ent_raw, sensor_exit_raw : raw asynchronous presence sensors
//   clr_err                         : one-cycle clear of count_err
//   sensor_entrance, sensor_exit    : debounced levels
//   entry_pulse, exit_pulse         : one-cycle clean rising-edge pulses
//   ent_fault, exit_fault           : stuck-high indication per channel
//   occupancy, lot_full, lot_empty  : lot count and its flags
//   count_err                       : sticky over/underflow attempt flag
// master: environment side; slave: the conditioner.
interface parking_sensor_conditioner_if #(
   parameter int unsigned CNT_W = 4
);
   logic             sensor_ent_raw;
   logic             sensor_exit_raw;
   logic             clr_err;
   logic             sensor_entrance;
   logic             sensor_exit;
   logic             entry_pulse;
   logic             exit_pulse;
   logic             ent_fault;
   logic             exit_fault;
   logic [CNT_W-1:0] occupancy;
   logic             lot_full;
   logic             lot_empty;
   logic             count_err;

   modport master (
      output sensor_ent_raw, sensor_exit_raw, clr_err,
      input  sensor_entrance, sensor_exit, entry_pulse, exit_pulse,
             ent_fault, exit_fault, occupancy, lot_full, lot_empty, count_err
   );

   modport slave (
      input  sensor_ent_raw, sensor_exit_raw, clr_err,
      output sensor_entrance, sensor_exit, entry_pulse, exit_pulse,
             ent_fault, exit_fault, occupancy, lot_full, lot_empty, count_err
   );
endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter, clean level,
// registered rising-edge pulse and stuck-high detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_raw        : raw asynchronous sensor input
//   o_clean      : debounced level
//   o_rise       : one cycle, coincident with the clean level rising
//   o_fault      : clean level has been high for STUCK_CYCLES cycles
module sensor_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned STUCK_CYCLES    = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_clean,
   output logic o_rise,
   output logic o_fault
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_clean;
   logic            r_rise;
   logic [DB_W-1:0] r_db_cnt;
   logic [ST_W-1:0] r_st_cnt;

   logic w_mismatch;
   logic w_accept;

   assign w_mismatch = r_sync2 ^ r_clean;
   // Counter has already seen DEBOUNCE_CYCLES mismatches and this edge is one
   // more: the new level is accepted, giving DEBOUNCE_CYCLES+2 raw-to-clean latency.
   assign w_accept   = w_mismatch && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_clean  <= 1'b0;
         r_rise   <= 1'b0;
         r_db_cnt <= '0;
         r_st_cnt <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;

         if (!w_mismatch || w_accept) begin
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end

         if (w_accept) begin
            r_clean <= ~r_clean;
         end
         r_rise <= w_accept & ~r_clean;

         if (!r_clean) begin
            r_st_cnt <= '0;
         end else if (r_st_cnt != ST_W'(STUCK_CYCLES)) begin
            r_st_cnt <= r_st_cnt + 1'b1;
         end
      end
   end

   assign o_clean = r_clean;
   assign o_rise  = r_rise;
   assign o_fault = (r_st_cnt == ST_W'(STUCK_CYCLES));

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Front end of the parking gate controller: conditions the entrance and exit
// presence sensors and keeps a saturating lot occupancy count.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : raw sensors and clr_err in; clean levels, arrival pulses,
//                  stuck faults, occupancy, lot_full/lot_empty, count_err out
module parking_sensor_conditioner
   import parking_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned STUCK_CYCLES    = 1024,
   parameter int unsigned CAPACITY        = CAPACITY_DEF,
   parameter int unsigned CNT_W           = 4
) (
   input logic                         clk,
   input logic                         reset_n,
   parking_sensor_conditioner_if.slave bus
);

   logic w_ent_clean;
   logic w_ent_pulse;
   logic w_ent_fault;
   logic w_exit_clean;
   logic w_exit_pulse;
   logic w_exit_fault;

   sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_ent (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (bus.sensor_ent_raw),
      .o_clean (w_ent_clean),
      .o_rise  (w_ent_pulse),
      .o_fault (w_ent_fault)
   );

   sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_exit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (bus.sensor_exit_raw),
      .o_clean (w_exit_clean),
      .o_rise  (w_exit_pulse),
      .o_fault (w_exit_fault)
   );

   logic [CNT_W-1:0] r_occ;
   logic             r_full;
   logic             r_empty;
   logic             r_err;

   occ_op_t          w_op;
   logic             w_err_set;
   logic [CNT_W-1:0] w_occ_next;

   // Simultaneous entry and exit cancel out, even at the full/empty limits.
   always_comb begin
      w_op       = OCC_HOLD;
      w_err_set  = 1'b0;
      w_occ_next = r_occ;
      if (w_ent_pulse && !w_exit_pulse) begin
         if (r_occ != CNT_W'(CAPACITY)) begin
            w_op = OCC_INC;
         end else begin
            w_err_set = 1'b1;
         end
      end else if (w_exit_pulse && !w_ent_pulse) begin
         if (r_occ != '0) begin
            w_op = OCC_DEC;
         end else begin
            w_err_set = 1'b1;
         end
      end
      case (w_op)
         OCC_INC: w_occ_next = r_occ + 1'b1;
         OCC_DEC: w_occ_next = r_occ - 1'b1;
         default: w_occ_next = r_occ;
      endcase
   end

   // Flags are registered from the next count so they stay coherent with occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_occ   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_err   <= 1'b0;
      end else begin
         r_occ   <= w_occ_next;
         r_full  <= (w_occ_next == CNT_W'(CAPACITY));
         r_empty <= (w_occ_next == '0);
         r_err   <= w_err_set | (r_err & ~bus.clr_err);
      end
   end

   assign bus.sensor_entrance = w_ent_clean;
   assign bus.sensor_exit     = w_exit_clean;
   assign bus.entry_pulse     = w_ent_pulse;
   assign bus.exit_pulse      = w_exit_pulse;
   assign bus.ent_fault       = w_ent_fault;
   assign bus.exit_fault      = w_exit_fault;
   assign bus.occupancy       = r_occ;
   assign bus.lot_full        = r_full;
   assign bus.lot_empty       = r_empty;
   assign bus.count_err       = r_err;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Bench for parking_sensor_conditioner with DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=20, CAPACITY=3, CNT_W=2.
module tb_parking_sensor_conditioner;

   localparam int D     = 4;
   localparam int S     = 20;
   localparam int CAP   = 3;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   parking_sensor_conditioner_if #(.CNT_W(CNT_W)) bus ();

   parking_sensor_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .STUCK_CYCLES    (S),
      .CAPACITY        (CAP),
      .CNT_W           (CNT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A clean level flips once the last D+1 synchroniser outputs all disagree with it.
   bit m_s1[2], m_s2[2], m_clean[2], m_pulse[2], m_fault[2];
   bit hist[2][D+1];
   int nsamp[2];
   int rise_e[2];
   int e = 0;
   int m_occ = 0;
   bit m_err = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_clean[c] = 0; m_pulse[c] = 0; m_fault[c] = 0;
            nsamp[c] = 0; rise_e[c] = 0;
            for (int k = 0; k <= D; k++) hist[c][k] = 0;
         end
         e = 0; m_occ = 0; m_err = 0;
      end else begin
         bit raw_v[2];
         bit pe, px, set;
         raw_v[0] = bus.sensor_ent_raw;
         raw_v[1] = bus.sensor_exit_raw;
         pe = m_pulse[0]; px = m_pulse[1];
         set = 0;
         if (pe && !px) begin
            if (m_occ < CAP) m_occ++; else set = 1;
         end else if (px && !pe) begin
            if (m_occ > 0) m_occ--; else set = 1;
         end
         if (set) m_err = 1;
         else if (bus.clr_err) m_err = 0;
         for (int c = 0; c < 2; c++) begin
            bit syn, all;
            syn = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = raw_v[c];
            for (int k = D; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = syn;
            if (nsamp[c] < D + 1) nsamp[c]++;
            m_fault[c] = m_clean[c] && (e - rise_e[c] >= S);
            all = (nsamp[c] == D + 1);
            for (int k = 0; k <= D; k++) if (hist[c][k] == m_clean[c]) all = 0;
            m_pulse[c] = 0;
            if (all) begin
               m_clean[c] = !m_clean[c];
               if (m_clean[c]) begin
                  m_pulse[c] = 1;
                  rise_e[c] = e;
               end
            end
         end
         e++;
      end
   end

   always @(negedge clk) begin
      logic [10:0] act, exp;
      act = {bus.sensor_entrance, bus.sensor_exit, bus.entry_pulse, bus.exit_pulse,
             bus.ent_fault, bus.exit_fault, bus.occupancy, bus.lot_full,
             bus.lot_empty, bus.count_err};
      exp = {m_clean[0], m_clean[1], m_pulse[0], m_pulse[1], m_fault[0], m_fault[1],
             CNT_W'(m_occ), (m_occ == CAP), (m_occ == 0), m_err};
      chk("model_vector", int'(act), int'(exp));
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_entry();
      bus.sensor_ent_raw = 1'b1;
      wait_edges(8);
      bus.sensor_ent_raw = 1'b0;
      wait_edges(8);
   endtask

   task automatic do_exit();
      bus.sensor_exit_raw = 1'b1;
      wait_edges(8);
      bus.sensor_exit_raw = 1'b0;
      wait_edges(8);
   endtask

   task automatic do_clr();
      bus.clr_err = 1'b1;
      wait_edges(1);
      bus.clr_err = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      bus.sensor_ent_raw  = 1'b0;
      bus.sensor_exit_raw = 1'b0;
      bus.clr_err         = 1'b0;
      wait_edges(3);
      chk("reset_occupancy", int'(bus.occupancy), 0);
      chk("reset_lot_empty", int'(bus.lot_empty), 1);
      chk("reset_sensor_entrance", int'(bus.sensor_entrance), 0);
      chk("reset_count_err", int'(bus.count_err), 0);
      reset_n = 1'b1;
      wait_edges(3);

      // 1: entrance latency
      bus.sensor_ent_raw = 1'b1;
      wait_edges(6);
      chk("t1_clean_before_e6", int'(bus.sensor_entrance), 0);
      wait_edges(1);
      chk("t1_clean_e6", int'(bus.sensor_entrance), 1);
      chk("t1_pulse_e6", int'(bus.entry_pulse), 1);
      chk("t1_occ_e6", int'(bus.occupancy), 0);
      wait_edges(1);
      chk("t1_occ_e7", int'(bus.occupancy), 1);
      chk("t1_empty_e7", int'(bus.lot_empty), 0);
      chk("t1_pulse_e7", int'(bus.entry_pulse), 0);
      bus.sensor_ent_raw = 1'b0;
      wait_edges(10);
      chk("t1_clean_fall", int'(bus.sensor_entrance), 0);

      // 2: glitches shorter than the acceptance window
      bus.sensor_ent_raw = 1'b1;
      wait_edges(3);
      bus.sensor_ent_raw = 1'b0;
      wait_edges(6);
      for (int i = 0; i < 3; i++) begin
         bus.sensor_ent_raw = 1'b1;
         wait_edges(4);
         bus.sensor_ent_raw = 1'b0;
         wait_edges(4);
      end
      wait_edges(8);
      chk("t2_no_clean", int'(bus.sensor_entrance), 0);
      chk("t2_occ", int'(bus.occupancy), 1);

      // 3: fill to capacity and overflow
      do_exit();
      chk("t3_occ0", int'(bus.occupancy), 0);
      do_entry();
      chk("t3_occ1", int'(bus.occupancy), 1);
      do_entry();
      chk("t3_occ2", int'(bus.occupancy), 2);
      do_entry();
      chk("t3_occ3", int'(bus.occupancy), 3);
      chk("t3_full", int'(bus.lot_full), 1);
      chk("t3_err_at3", int'(bus.count_err), 0);
      do_entry();
      chk("t3_occ_sat", int'(bus.occupancy), 3);
      chk("t3_err_set", int'(bus.count_err), 1);
      do_clr();
      chk("t3_err_clr", int'(bus.count_err), 0);

      // 4: simultaneous pulses at full, then underflow
      bus.sensor_ent_raw  = 1'b1;
      bus.sensor_exit_raw = 1'b1;
      wait_edges(8);
      bus.sensor_ent_raw  = 1'b0;
      bus.sensor_exit_raw = 1'b0;
      wait_edges(8);
      chk("t4_both_occ", int'(bus.occupancy), 3);
      chk("t4_both_err", int'(bus.count_err), 0);
      for (int i = 0; i < 3; i++) do_exit();
      chk("t4_occ0", int'(bus.occupancy), 0);
      chk("t4_empty", int'(bus.lot_empty), 1);
      do_exit();
      chk("t4_under_occ", int'(bus.occupancy), 0);
      chk("t4_under_err", int'(bus.count_err), 1);
      do_clr();

      // 5: stuck exit sensor
      bus.sensor_exit_raw = 1'b1;
      wait_edges(26);
      chk("t5_fault_e25", int'(bus.exit_fault), 0);
      wait_edges(1);
      chk("t5_fault_e26", int'(bus.exit_fault), 1);
      wait_edges(3);
      bus.sensor_exit_raw = 1'b0;
      wait_edges(7);
      chk("t5_clean_fell", int'(bus.sensor_exit), 0);
      chk("t5_fault_hold", int'(bus.exit_fault), 1);
      wait_edges(1);
      chk("t5_fault_clr", int'(bus.exit_fault), 0);
      wait_edges(4);

      // 6: reset mid-debounce
      do_entry();
      do_entry();
      chk("t6_occ2", int'(bus.occupancy), 2);
      bus.sensor_ent_raw = 1'b1;
      wait_edges(4);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_occ", int'(bus.occupancy), 0);
      chk("t6_rst_empty", int'(bus.lot_empty), 1);
      chk("t6_rst_full", int'(bus.lot_full), 0);
      chk("t6_rst_err", int'(bus.count_err), 0);
      chk("t6_rst_clean", int'(bus.sensor_entrance), 0);
      wait_edges(2);
      reset_n = 1'b1;
      wait_edges(6);
      chk("t6_clean_before_e6", int'(bus.sensor_entrance), 0);
      wait_edges(1);
      chk("t6_clean_e6", int'(bus.sensor_entrance), 1);
      chk("t6_pulse_e6", int'(bus.entry_pulse), 1);
      wait_edges(1);
      chk("t6_occ_e7", int'(bus.occupancy), 1);
      bus.sensor_ent_raw = 1'b0;
      wait_edges(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
